// File: rtl/com_uart_pkg.sv
// Shared types and helpers for the com_uart serial port.
// Holds the TX/RX state encoding and bit-timing arithmetic.
package com_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return clk_freq / baud;
    endfunction

    // Counter only ever reaches CLKS_PER_BIT-1, so $clog2 bits suffice.
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/com_uart_rx.sv
// Receive half of com_uart: synchronizer, framing FSM and a
// one-cycle strobe when a byte with a valid stop bit completes.
module com_uart_rx
    import com_uart_pkg::*;
#(
    parameter int CPB = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CW = cnt_width(CPB);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

    logic [1:0]    sync_q;
    logic          rxd_s;
    logic          prev_q;
    logic          fall;

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          cnt_last;

    assign rxd_s    = sync_q[1];
    assign fall     = prev_q & ~rxd_s;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            prev_q  <= rxd_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                // Mid-start check rejects glitches shorter than half a bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shreg_d = {rxd_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid = 1'b0;
        unique case (1'b1)
            (state_q == ST_STOP): valid = cnt_last & rxd_s;
            default:              valid = 1'b0;
        endcase
    end

    assign data = shreg_q;

endmodule

// File: rtl/com_uart.sv
// 8N1 UART with a byte-wide host port, level read interrupt
// and sticky overrun; transmitter and host flags live here.
module com_uart
    import com_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] com_data_out,
    input  logic       enable_com_write,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    output logic       com_write_ready,
    input  logic       int_com_ack,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       com_overrun
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = cnt_width(CPB);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    uart_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shreg_q, tx_shreg_d;
    logic          tx_cnt_last;

    logic [7:0]    rx_data;
    logic          rx_valid;

    assign tx_cnt_last = (tx_cnt_q == CNT_LAST);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (enable_com_write) begin
                    tx_shreg_d = com_data_out;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_last) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_cnt_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_txd        = 1'b1;
        com_write_ready = 1'b0;
        unique case (1'b1)
            (tx_state_q == ST_IDLE):  com_write_ready = 1'b1;
            (tx_state_q == ST_START): uart_txd = 1'b0;
            (tx_state_q == ST_DATA):  uart_txd = tx_shreg_q[tx_bit_q];
            default:                  uart_txd = 1'b1;
        endcase
    end

    com_uart_rx #(
        .CPB (CPB)
    ) u_rx (
        .clk   (clk50M),
        .rst_n (rst_n),
        .rxd   (uart_rxd),
        .data  (rx_data),
        .valid (rx_valid)
    );

    // A completing byte takes priority over a simultaneous ack.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            com_data_in    <= '0;
            com_read_ready <= 1'b0;
            com_overrun    <= 1'b0;
        end else if (rx_valid) begin
            com_data_in    <= rx_data;
            com_read_ready <= 1'b1;
            if (com_read_ready && !int_com_ack) com_overrun <= 1'b1;
        end else if (int_com_ack) begin
            com_read_ready <= 1'b0;
            com_overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_com_uart.sv
// Self-checking bench for com_uart at 16 clocks per bit.
// Line-level model: frames built from bytes, host flags tracked by rules.
module tb_com_uart;

    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk50M;
    logic       rst_n;
    logic [7:0] com_data_out;
    logic       enable_com_write;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       com_write_ready;
    logic       int_com_ack;
    logic       uart_rxd;
    logic       uart_txd;
    logic       com_overrun;

    int n_chk;
    int n_fail;
    int lat_ref;

    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ovr;

    com_uart #(
        .CLK_FREQ (1600),
        .BAUD     (100)
    ) dut (
        .clk50M           (clk50M),
        .rst_n            (rst_n),
        .com_data_out     (com_data_out),
        .enable_com_write (enable_com_write),
        .com_data_in      (com_data_in),
        .com_read_ready   (com_read_ready),
        .com_write_ready  (com_write_ready),
        .int_com_ack      (int_com_ack),
        .uart_rxd         (uart_rxd),
        .uart_txd         (uart_txd),
        .com_overrun      (com_overrun)
    );

    initial clk50M = 1'b0;
    always #5 clk50M = ~clk50M;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk50M);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_data"}, com_data_in, m_data);
        check({tag, "_ready"}, com_read_ready, m_ready);
        check({tag, "_ovr"}, com_overrun, m_ovr);
    endtask

    // Called at a negedge; decodes the line back into a byte.
    task automatic tx_frame(
        input logic [7:0] b,
        input int         inject_at
    );
        logic [9:0] fr;
        logic [7:0] dec;
        int cyc;
        int errs;
        int idx;
        fr = {1'b1, b, 1'b0};
        dec = '0;
        check("tx_ready_pre", com_write_ready, 1);
        com_data_out = b;
        enable_com_write = 1'b1;
        @(negedge clk50M);
        enable_com_write = 1'b0;
        com_data_out = ~b;
        cyc = 0;
        errs = 0;
        while (!com_write_ready && cyc < 400) begin
            idx = cyc / CPB;
            if (idx < 10 && uart_txd !== fr[idx]) errs++;
            if (cyc % CPB == CPB / 2 && idx >= 1 && idx <= 8)
                dec[idx-1] = uart_txd;
            if (cyc == inject_at) begin
                enable_com_write = 1'b1;
                com_data_out = b ^ 8'hFF;
            end else begin
                enable_com_write = 1'b0;
            end
            @(negedge clk50M);
            cyc++;
        end
        enable_com_write = 1'b0;
        check("tx_busy_len", cyc, FRAME);
        check("tx_wave_err", errs, 0);
        check("tx_byte", dec, b);
        check("tx_idle_line", uart_txd, 1);
    endtask

    // Drives one frame from a negedge; ack_at>=0 means ack coincides
    // with the completion cycle.
    task automatic send_rx(
        input  logic [7:0] b,
        input  logic       stop,
        input  int         ack_at,
        output int         lat
    );
        logic [9:0] fr;
        logic was;
        logic coinc;
        fr = {stop, b, 1'b0};
        was = com_read_ready;
        coinc = (ack_at >= 0);
        lat = -1;
        for (int c = 0; c < FRAME; c++) begin
            uart_rxd = fr[c/CPB];
            int_com_ack = (c == ack_at);
            if (lat < 0 && !was && com_read_ready) lat = c;
            @(negedge clk50M);
        end
        int_com_ack = 1'b0;
        uart_rxd = 1'b1;
        if (stop) begin
            if (m_ready && !coinc) m_ovr = 1'b1;
            m_data = b;
            m_ready = 1'b1;
        end else if (coinc) begin
            m_ready = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic ack_cycles(input int n);
        int_com_ack = 1'b1;
        idle(n);
        int_com_ack = 1'b0;
        m_ready = 1'b0;
        m_ovr = 1'b0;
        idle(1);
    endtask

    task automatic model_reset();
        m_data = '0;
        m_ready = 1'b0;
        m_ovr = 1'b0;
    endtask

    initial begin
        int lat;
        int op;
        logic [7:0] rb;
        n_chk = 0;
        n_fail = 0;
        lat_ref = -1;
        model_reset();
        rst_n = 1'b0;
        com_data_out = '0;
        enable_com_write = 1'b0;
        int_com_ack = 1'b0;
        uart_rxd = 1'b1;
        idle(3);
        check("rst_txd", uart_txd, 1);
        check("rst_wready", com_write_ready, 1);
        check_rx("rst");
        rst_n = 1'b1;
        idle(2);

        tx_frame(8'hA5, -1);

        send_rx(8'h3C, 1'b1, -1, lat);
        check("rx_lat_window",
              (lat >= 9 * CPB + CPB / 2 && lat <= 9 * CPB + CPB / 2 + 4), 1);
        if (lat > 0) lat_ref = lat;
        idle(3);
        check_rx("rx_3c");
        ack_cycles(3);
        check_rx("rx_3c_ack");

        send_rx(8'h11, 1'b1, -1, lat);
        idle(5);
        send_rx(8'h22, 1'b1, -1, lat);
        idle(3);
        check_rx("rx_ovr");
        ack_cycles(1);
        check_rx("rx_ovr_ack");

        uart_rxd = 1'b0;
        idle(6);
        uart_rxd = 1'b1;
        idle(30);
        check_rx("rx_glitch");
        send_rx(8'h55, 1'b0, -1, lat);
        idle(3);
        check_rx("rx_ferr");

        tx_frame(8'h3E, 40);
        idle(2);

        com_data_out = 8'hC3;
        enable_com_write = 1'b1;
        idle(1);
        enable_com_write = 1'b0;
        idle(50);
        rst_n = 1'b0;
        #1;
        check("midtx_rst_txd", uart_txd, 1);
        check("midtx_rst_wready", com_write_ready, 1);
        model_reset();
        idle(1);
        check("midtx_rst_txd2", uart_txd, 1);
        check_rx("midtx_rst");
        rst_n = 1'b1;
        tx_frame(8'h69, -1);

        send_rx(8'h81, 1'b1, -1, lat);
        idle(3);
        if (lat_ref > 0) begin
            send_rx(8'h7E, 1'b1, lat_ref - 1, lat);
            idle(3);
            check_rx("rx_ack_coinc");
        end
        ack_cycles(2);

        fork
            tx_frame(8'h5A, -1);
            send_rx(8'hC7, 1'b1, -1, lat);
        join
        idle(3);
        check_rx("full_duplex");

        for (int i = 0; i < 14; i++) begin
            op = int'($urandom_range(0, 5));
            rb = 8'($urandom);
            if (op <= 2) begin
                if (op == 2 && lat_ref > 0)
                    send_rx(rb, 1'b1, lat_ref - 1, lat);
                else
                    send_rx(rb, 1'b1, -1, lat);
            end else if (op == 3) begin
                send_rx(rb, 1'b0, -1, lat);
            end else if (op == 4) begin
                ack_cycles(int'($urandom_range(1, 4)));
            end else begin
                tx_frame(rb, int'($urandom_range(0, 150)));
            end
            idle(int'($urandom_range(3, 12)));
            check_rx("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/com_uart.md
COM_UART -- requirements
Module: com_uart

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (434 at defaults).
REQ-003 clk50M  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 com_data_out  in  8  byte to transmit, sampled when enable_com_write=1.
REQ-006 enable_com_write  in  1  transmit request strobe.
REQ-007 com_data_in  out  8  last received byte, held until the next good byte.
REQ-008 com_read_ready  out  1  received byte pending; level interrupt source.
REQ-009 com_write_ready  out  1  transmitter idle and able to accept a byte.
REQ-010 int_com_ack  in  1  read acknowledge; level, may stay high several cycles.
REQ-011 uart_rxd  in  1  asynchronous serial input, idle high.
REQ-012 uart_txd  out  1  serial output, idle high.
REQ-013 com_overrun  out  1  sticky flag: a byte arrived while com_read_ready=1.

Function
REQ-014 Frame format SHALL be 8N1: start 0, 8 data bits LSB first, one stop bit 1, each CLKS_PER_BIT cycles.
REQ-015 TX states SHALL be IDLE, START, DATA, STOP; com_write_ready=1 only in IDLE.
REQ-016 In IDLE with enable_com_write=1, TX SHALL latch com_data_out, go to START on the next cycle and drive uart_txd=0 from that cycle.
REQ-017 enable_com_write while not IDLE SHALL be ignored, with no queueing and no corruption of the frame in flight.
REQ-018 TX SHALL return to IDLE, and raise com_write_ready, exactly 10*CLKS_PER_BIT cycles after leaving IDLE.
REQ-019 uart_rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-020 RX states SHALL be IDLE, START, DATA, STOP; IDLE exits on synchronized 1->0 transition.
REQ-021 START SHALL re-sample at CLKS_PER_BIT/2; if the line is high, RX returns to IDLE (false start, no side effects).
REQ-022 Data and stop bits SHALL be sampled at CLKS_PER_BIT intervals after the mid-start sample.
REQ-023 On stop sample = 1, com_data_in SHALL update and com_read_ready SHALL be 1 on the following cycle.
REQ-024 On stop sample = 0 (framing error), the byte SHALL be discarded, with no change to com_data_in, com_read_ready or com_overrun.
REQ-025 int_com_ack=1 SHALL clear com_read_ready and com_overrun on the next cycle.
REQ-026 Good byte completion coinciding with int_com_ack SHALL win: data updates, com_read_ready stays 1, com_overrun unchanged.
REQ-027 Good byte completion with com_read_ready=1 and no ack SHALL overwrite com_data_in and set com_overrun.
REQ-028 TX and RX SHALL operate fully independently; simultaneous transmit and receive SHALL be supported.
REQ-029 Bit counters SHALL be sized $clog2(CLKS_PER_BIT) bits; no counter wraps before the state that uses it exits.

Reset
REQ-030 While rst_n=0: uart_txd=1, com_write_ready=1, com_read_ready=0, com_overrun=0, com_data_in=0, both FSMs IDLE, synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL abort immediately, with no partial byte delivered; after release, TX accepts a request on the first cycle.

Structure
REQ-032 Package com_uart_pkg SHALL hold the TX/RX state enum and the CLKS_PER_BIT function.
REQ-033 Receiver SHALL be sub-module com_uart_rx, covering synchronizer, RX FSM, data and stop strobe; transmitter, ready/overrun logic stay in com_uart.

Verification (CLK_FREQ=1600, BAUD=100, CLKS_PER_BIT=16)
REQ-034 Write 0xA5 -> uart_txd waveform 0,1,0,1,0,0,1,0,1,1, 16 cycles each; com_write_ready low exactly 160 cycles.
REQ-035 Drive RX frame 0x3C -> com_read_ready=1, com_data_in=0x3C; ack for 3 cycles -> ready=0, data still 0x3C.
REQ-036 Two frames 0x11 then 0x22, no ack -> com_data_in=0x22, com_overrun=1; ack clears both flags.
REQ-037 6-cycle low glitch on uart_rxd -> no ready; frame 0x55 with stop=0 -> no ready, data unchanged.
REQ-038 Second write during TX frame -> ignored, only the first byte on the line; rst_n pulse mid-TX -> uart_txd=1, ready=1 next cycle.
REQ-039 Good byte completion in the same cycle as ack -> com_read_ready remains 1 with the new byte.
